// File: rtl/if_pkg.sv
// Shared definitions for the prefetching instruction-fetch stage.
//   BR_BUS_W / FS_DS_BUS_W : widths of the decode-side buses
//   INST_SIZE_WORD         : bus size code for a 32-bit access
//   RESET_PC_DEFAULT       : default address of the first fetch after reset
//   br_bus_t / unpack_br_bus : field layout of {br_stall, br_taken, br_target}
package if_pkg;

    localparam int unsigned BR_BUS_W         = 34;
    localparam int unsigned FS_DS_BUS_W      = 64;
    localparam logic [1:0]  INST_SIZE_WORD   = 2'b10;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef struct packed {
        logic        stall;
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    function automatic br_bus_t unpack_br_bus(input logic [BR_BUS_W-1:0] bus);
        br_bus_t b;
        b.stall  = bus[33];
        b.taken  = bus[32];
        b.target = bus[31:0];
        return b;
    endfunction

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order slot queue for prefetched instructions.
// Each slot holds {pc, inst, filled}. tail allocates a slot when a request is
// accepted, fill points at the oldest slot still waiting for its response, and
// head is the oldest slot (the one presented to decode).
//   clk, reset           : clock, synchronous active-high reset
//   alloc, alloc_pc      : allocate slot at tail for a newly accepted request
//   fill, fill_inst      : write response data into the slot at fill
//   pop                  : retire the head slot
//   flush                : empty the queue (head = fill = tail)
//   head_pc, head_inst   : contents of the head slot
//   head_filled          : head slot has its instruction
//   used                 : allocated slots (tail - head)
//   unfilled             : allocated slots still awaiting data (tail - fill)
module fetch_slot_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc,
    input  logic [31:0]              alloc_pc,
    input  logic                     fill,
    input  logic [31:0]              fill_inst,
    input  logic                     pop,
    input  logic                     flush,
    output logic [31:0]              head_pc,
    output logic [31:0]              head_inst,
    output logic                     head_filled,
    output logic [$clog2(DEPTH):0]   used,
    output logic [$clog2(DEPTH):0]   unfilled
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] fill_q, fill_d;

    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      inst_q [DEPTH];
    logic [DEPTH-1:0] filled_q;

    logic [IW-1:0] head_idx;
    logic [IW-1:0] tail_idx;
    logic [IW-1:0] fill_idx;

    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];
    assign fill_idx = fill_q[IW-1:0];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        fill_d = fill_q;
        if (flush) begin
            head_d = tail_q;
            fill_d = tail_q;
        end else begin
            if (alloc) tail_d = tail_q + PW'(1);
            if (fill)  fill_d = fill_q + PW'(1);
            if (pop)   head_d = head_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            fill_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            fill_q <= fill_d;
        end
    end

    // Allocate, fill and pop always target distinct slots: fill trails tail,
    // pop needs a filled head, and allocation needs a free slot.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            filled_q <= '0;
        end else begin
            if (alloc) filled_q[tail_idx] <= 1'b0;
            if (fill)  filled_q[fill_idx] <= 1'b1;
            if (pop)   filled_q[head_idx] <= 1'b0;
        end
    end

    // Payload storage needs no reset; filled_q qualifies it.
    always_ff @(posedge clk) begin
        if (alloc && !flush) pc_q[tail_idx]   <= alloc_pc;
        if (fill && !flush)  inst_q[fill_idx] <= fill_inst;
    end

    assign head_pc     = pc_q[head_idx];
    assign head_inst   = inst_q[head_idx];
    assign head_filled = filled_q[head_idx];
    assign used        = tail_q - head_q;
    assign unfilled    = tail_q - fill_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// Decoupled instruction-fetch stage with a multi-request prefetcher.
// Issues sequential word fetches on an SRAM-like bus (addr_ok/data_ok, several
// requests in flight), buffers responses in order in fetch_slot_queue and
// presents the oldest filled instruction to decode.
//   clk, reset              : clock, synchronous active-high reset
//   ds_allow_in             : decode accepts the presented instruction
//   br_bus                  : {br_stall, br_taken, br_target}
//   inst_req .. inst_wdata  : instruction bus request side
//   inst_addr_ok            : request accepted this cycle
//   inst_data_ok/inst_rdata : in-order response
//   fs_ds_bus               : {pc, inst} of the queue head
//   fs_to_ds_valid          : head instruction is valid for decode
module if_prefetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ds_allow_in,
    input  logic [BR_BUS_W-1:0]    br_bus,
    output logic                   inst_req,
    output logic                   inst_wr,
    output logic [1:0]             inst_size,
    output logic [31:0]            inst_addr,
    output logic [31:0]            inst_wdata,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    input  logic [31:0]            inst_rdata,
    output logic [FS_DS_BUS_W-1:0] fs_ds_bus,
    output logic                   fs_to_ds_valid
);

    localparam int unsigned CW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_CNT = (CW + 1)'(DEPTH);
    // Stale responses pile up across back-to-back redirects while new fetches
    // are already outstanding, so the counter is wider than the queue.
    localparam int unsigned DISC_W = 8;

    br_bus_t br;
    assign br = unpack_br_bus(br_bus);

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [DISC_W-1:0] discard_q, discard_d;

    logic              q_alloc;
    logic              q_fill;
    logic              q_pop;
    logic [31:0]       head_pc;
    logic [31:0]       head_inst;
    logic              head_filled;
    logic [CW:0]       used;
    logic [CW:0]       unfilled;

    fetch_slot_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk         (clk),
        .reset       (reset),
        .alloc       (q_alloc),
        .alloc_pc    (fetch_pc_q),
        .fill        (q_fill),
        .fill_inst   (inst_rdata),
        .pop         (q_pop),
        .flush       (br.taken),
        .head_pc     (head_pc),
        .head_inst   (head_inst),
        .head_filled (head_filled),
        .used        (used),
        .unfilled    (unfilled)
    );

    assign inst_wr    = 1'b0;
    assign inst_size  = INST_SIZE_WORD;
    assign inst_wdata = 32'h0;
    assign inst_addr  = fetch_pc_q;
    assign inst_req   = ~reset & ~br.stall & ~br.taken & (used < DEPTH_CNT);

    assign q_alloc = inst_req & inst_addr_ok;
    // Responses owed to pre-redirect requests are swallowed, as is any
    // response landing in the redirect cycle itself.
    assign q_fill  = inst_data_ok & ~br.taken & (discard_q == '0);

    assign fs_to_ds_valid = ~reset & ~br.taken & head_filled & (used != '0);
    assign fs_ds_bus      = {head_pc, head_inst};
    assign q_pop          = fs_to_ds_valid & ds_allow_in;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (br.taken) begin
            fetch_pc_d = br.target;
        end else if (q_alloc) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_comb begin
        discard_d = discard_q;
        if (br.taken) begin
            discard_d = discard_q + DISC_W'(unfilled) - DISC_W'(inst_data_ok);
        end else if (inst_data_ok && discard_q != '0) begin
            discard_d = discard_q - DISC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomized self-checking bench for if_prefetch_stage. A bus responder returns
// hash(addr) for each accepted request after a random latency; a queue-based
// model of the fetch stage predicts inst_req/inst_addr/fs_to_ds_valid/fs_ds_bus
// every cycle. Directed phases pin the model with literal expectations.
module tb_if_prefetch_stage;
    import if_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allow_in;
    logic [33:0] br_bus;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [63:0] fs_ds_bus;
    logic        fs_to_ds_valid;

    always #5 clk = ~clk;

    if_prefetch_stage #(
        .RESET_PC (RPC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ds_allow_in    (ds_allow_in),
        .br_bus         (br_bus),
        .inst_req       (inst_req),
        .inst_wr        (inst_wr),
        .inst_size      (inst_size),
        .inst_addr      (inst_addr),
        .inst_wdata     (inst_wdata),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .fs_ds_bus      (fs_ds_bus),
        .fs_to_ds_valid (fs_to_ds_valid)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        int          ready;
    } req_t;

    ent_t        mq[$];       // model: allocated entries, oldest first
    logic [31:0] m_pc;
    int          m_disc;
    req_t        pend[$];     // bus: accepted requests awaiting response
    logic [31:0] acc_log[$];  // addresses the model saw accepted
    logic [31:0] pop_log[$];  // pcs the model saw handed to decode
    int          cyc = 0;
    int          lat_max = 2;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int ok_pct, input int data_pct, input int allow_pct,
                        input bit stall, input bit taken, input logic [31:0] tgt,
                        input bit rst);
        bit          exp_req;
        bit          exp_valid;
        bit          popped;
        int          unf;
        int          k;
        reset        = rst;
        ds_allow_in  = ($urandom_range(99) < allow_pct);
        inst_addr_ok = ($urandom_range(99) < ok_pct);
        br_bus       = {stall, taken, tgt};
        if (!rst && pend.size() > 0 && pend[0].ready <= cyc
            && $urandom_range(99) < data_pct) begin
            inst_data_ok = 1'b1;
            inst_rdata   = hash(pend[0].addr);
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = $urandom;
        end
        #1;
        exp_req   = !rst && !stall && !taken && mq.size() < DEPTH;
        exp_valid = !rst && !taken && mq.size() > 0 && mq[0].filled;
        check("inst_req", 64'(inst_req), 64'(exp_req));
        if (exp_req) check("inst_addr", 64'(inst_addr), 64'(m_pc));
        check("fs_to_ds_valid", 64'(fs_to_ds_valid), 64'(exp_valid));
        if (exp_valid) begin
            check("fs_ds_bus", fs_ds_bus, {mq[0].pc, mq[0].inst});
            check("inst_matches_pc", 64'(fs_ds_bus[31:0]), 64'(hash(fs_ds_bus[63:32])));
        end
        popped = exp_valid && ds_allow_in;
        @(posedge clk);
        cyc++;
        // bus side follows what the DUT actually did
        if (rst) begin
            pend.delete();
        end else begin
            if (inst_data_ok) void'(pend.pop_front());
            if (inst_req && inst_addr_ok)
                pend.push_back('{addr: inst_addr, ready: cyc + $urandom_range(lat_max)});
        end
        // model
        if (rst) begin
            mq.delete();
            m_pc   = RPC;
            m_disc = 0;
        end else if (taken) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_disc = m_disc + unf - int'(inst_data_ok);
            mq.delete();
            m_pc = tgt;
        end else begin
            if (inst_data_ok) begin
                if (m_disc > 0) begin
                    m_disc--;
                end else begin
                    k = -1;
                    foreach (mq[i]) if (k < 0 && !mq[i].filled) k = i;
                    if (k >= 0) begin
                        mq[k].inst   = inst_rdata;
                        mq[k].filled = 1'b1;
                    end
                end
            end
            if (popped) begin
                pop_log.push_back(mq[0].pc);
                void'(mq.pop_front());
            end
            if (exp_req && inst_addr_ok) begin
                acc_log.push_back(m_pc);
                mq.push_back('{pc: m_pc, inst: 32'h0, filled: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        int          n0;
        int          a0;
        bit          prev_taken;
        bit          tk;
        bit          st;
        int          ok_p;
        int          dat_p;
        int          alw_p;
        logic [31:0] tg;
        m_pc   = RPC;
        m_disc = 0;

        step(0, 0, 0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        check("inst_wr_tied", 64'(inst_wr), 64'h0);
        check("inst_size_word", 64'(inst_size), 64'h2);
        check("inst_wdata_tied", 64'(inst_wdata), 64'h0);

        // Fill the queue with decode blocked: only DEPTH requests accepted.
        for (int i = 0; i < 6; i++) step(100, 0, 0, 0, 0, 32'h0, 0);
        check("accepts_when_full", 64'(acc_log.size()), 64'd4);
        check("first_addr", 64'(acc_log[0]), 64'h8000_0000);
        check("fourth_addr", 64'(acc_log[3]), 64'h8000_000C);
        for (int i = 0; i < 20; i++) step(0, 100, 0, 0, 0, 32'h0, 0);
        step(0, 0, 100, 0, 0, 32'h0, 0);
        check("pop_count_one", 64'(pop_log.size()), 64'd1);
        check("first_pc", 64'(pop_log[0]), 64'h8000_0000);
        for (int i = 0; i < 3; i++) step(100, 0, 0, 0, 0, 32'h0, 0);
        check("accepts_after_pop", 64'(acc_log.size()), 64'd5);
        check("addr_after_pop", 64'(acc_log[4]), 64'h8000_0010);
        for (int i = 0; i < 20; i++) step(0, 100, 100, 0, 0, 32'h0, 0);
        check("drain_count", 64'(pop_log.size()), 64'd5);
        check("second_pc", 64'(pop_log[1]), 64'h8000_0004);
        check("third_pc", 64'(pop_log[2]), 64'h8000_0008);

        // Redirect with two requests in flight.
        step(100, 0, 0, 0, 0, 32'h0, 0);
        step(100, 0, 0, 0, 0, 32'h0, 0);
        n0 = pop_log.size();
        step(0, 0, 0, 0, 1, 32'h1C00_0100, 0);
        for (int i = 0; i < 30; i++) step(100, 100, 100, 0, 0, 32'h0, 0);
        if (pop_log.size() > n0) check("pc_after_branch", 64'(pop_log[n0]), 64'h1C00_0100);
        else check("pc_after_branch_seen", 64'(pop_log.size()), 64'(n0 + 1));

        // Stall with requests in flight: no new accepts, fetch resumes in sequence.
        for (int i = 0; i < 30; i++) step(0, 100, 100, 0, 0, 32'h0, 0);
        step(100, 0, 0, 0, 0, 32'h0, 0);
        step(100, 0, 0, 0, 0, 32'h0, 0);
        a0 = acc_log.size();
        for (int i = 0; i < 5; i++) step(100, 100, 100, 1, 0, 32'h0, 0);
        check("no_accept_in_stall", 64'(acc_log.size()), 64'(a0));
        step(100, 100, 100, 0, 0, 32'h0, 0);
        check("resume_sequential", 64'(acc_log[acc_log.size()-1]),
              64'(acc_log[a0-1] + 32'd4));

        // Randomized traffic with redirects, stalls and occasional resets.
        prev_taken = 1'b0;
        ok_p = 70; dat_p = 60; alw_p = 70;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                ok_p    = $urandom_range(100, 20);
                dat_p   = $urandom_range(100, 20);
                alw_p   = $urandom_range(100, 10);
                lat_max = $urandom_range(4);
            end
            tk = !prev_taken && ($urandom_range(99) < 4);
            st = !tk && ($urandom_range(99) < 10);
            tg = ($urandom_range(9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            prev_taken = tk;
            step(ok_p, dat_p, alw_p, st, tk, tg, ($urandom_range(999) < 3));
        end

        // Reset in the middle of a full queue.
        lat_max = 2;
        for (int i = 0; i < 15; i++) step(100, 100, 0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 1);
        check("valid_after_reset", 64'(fs_to_ds_valid), 64'h0);
        check("req_after_reset", 64'(inst_req), 64'h0);
        a0 = acc_log.size();
        step(100, 0, 0, 0, 0, 32'h0, 0);
        check("accept_after_reset", 64'(acc_log.size()), 64'(a0 + 1));
        check("first_fetch_after_reset", 64'(acc_log[acc_log.size()-1]), 64'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage that replaces the single-entry IF stage with a decoupled prefetcher. It drives an SRAM-like request/response instruction bus (addr_ok/data_ok handshake, multi-cycle latency, several requests in flight) and buffers fetched instructions in an in-order slot queue. It feeds decode over the existing {pc, inst} bus and valid/allow_in handshake, and takes branch redirect and stall from decode's br_bus. Branch redirect flushes the queue and discards stale responses still in flight.

Parameters:
RESET_PC, 32'h8000_0000, address of the first fetch after reset
DEPTH, 4, queue slots, which also caps total requests in flight plus buffered entries (power of 2, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ds_allow_in  in  1  decode can accept an instruction this cycle
br_bus  in  34  {br_stall, br_taken, br_target[31:0]}
inst_req  out  1  instruction bus request valid
inst_wr  out  1  tied 0
inst_size  out  2  tied 2'b10 (word)
inst_addr  out  32  request address
inst_wdata  out  32  tied 0
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  response valid this cycle (in request order)
inst_rdata  in  32  response data
fs_ds_bus  out  64  {pc[31:0], inst[31:0]} of the queue head
fs_to_ds_valid  out  1  head slot holds a valid filled instruction

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. All state is updated on posedge clk only.
- Reset sets fetch_pc to RESET_PC and clears head, tail and fill pointers, slot count and discard_cnt. Outputs in reset: inst_req=0, fs_to_ds_valid=0. Reset mid-operation drops all queue contents and in-flight bookkeeping. The bus is reset in the same cycle, so no stale response follows.
- Slot queue:
  - Circular buffer of DEPTH entries, each {pc, inst, filled}.
  - Three pointers: tail (allocate), fill (oldest unfilled), head (oldest).
  - used = tail - head, width clog2(DEPTH)+1.
- Request:
  - inst_req = ~reset & ~br_stall & ~br_taken & (used < DEPTH).
  - inst_addr = fetch_pc.
  - When inst_req & inst_addr_ok: allocate slot at tail with pc=fetch_pc and filled=0; tail++; fetch_pc += 4. Address wraps modulo 2^32.
- Response, when inst_data_ok:
  - If discard_cnt != 0: discard_cnt-- and drop the data.
  - Otherwise write inst_rdata into slot[fill], set filled=1, fill++.
  - Zero-cycle latency (addr_ok and data_ok for the same request in one cycle) is not supported. The bus guarantees data_ok at least one cycle after addr_ok.
- Output:
  - fs_to_ds_valid = slot[head].filled & (used != 0) & ~br_taken.
  - fs_ds_bus = {slot[head].pc, slot[head].inst}.
  - When fs_to_ds_valid & ds_allow_in: head++ and clear that slot's filled bit.
- Simultaneous events outside a branch: allocate, fill and pop in the same cycle are independent and all take effect.
- Branch redirect (br_taken=1, single-cycle pulse from decode; no delay slot):
  - fetch_pc <= br_target.
  - head, tail and fill are all set to the current tail, which empties the queue.
  - discard_cnt <= discard_cnt + (unfilled allocated slots) - (inst_data_ok this cycle). Any response arriving in the br_taken cycle is dropped.
  - inst_req and fs_to_ds_valid are 0 in that cycle.
  - The first request to br_target is issued the next cycle, even while discard_cnt > 0.
- br_stall=1 blocks new requests only. In-flight responses, fills and pops continue. fetch_pc holds.
- Full (used==DEPTH): inst_req=0 until a pop. Empty: fs_to_ds_valid=0.
- Latency: first fs_to_ds_valid appears one cycle after the data_ok of the first request.

Decomposition:
- Package if_pkg holds:
  - BR_BUS_W=34 and FS_DS_BUS_W=64
  - INST_SIZE_WORD=2'b10
  - default RESET_PC
  - the br_bus field-unpack order
- One sub-module, fetch_slot_queue (parametrised DEPTH):
  - contains the three pointers, used count and slot storage
  - alloc/fill/pop/flush ports
  - exposes head entry, head-filled and used.
- The top level holds fetch_pc, discard_cnt and the request/redirect logic.

Test Plan:
- Reset release, bus addr_ok=1, data_ok 2 cycles later: inst_addr=0x8000_0000, then 0x8000_0004, and so on; decode receives pc 0x8000_0000, 0x8000_0004, 0x8000_0008 in order with matching rdata.
- DEPTH=4, ds_allow_in=0: exactly 4 requests accepted, then inst_req=0; one pop leads to one new request (addr 0x8000_0010).
- addr_ok held low for 3 cycles: inst_req and inst_addr stay stable, and fetch_pc does not advance until acceptance.
- 2 requests in flight, br_taken with br_target=0x1C00_0100: both later data_ok responses are dropped, and the next decoded pc is 0x1C00_0100.
- br_taken in the same cycle as data_ok with 3 in flight: discard_cnt=2; the 4th response is delivered as pc br_target.
- br_stall=1 for 5 cycles with 2 in flight: no new req; both responses buffered and delivered; fetching resumes at the next sequential pc.
- reset asserted mid-stream with a full queue: next cycle fs_to_ds_valid=0 and inst_req=0; after release, first fetch is RESET_PC.
